// File: rtl/micro_seq.sv
// micro_seq: fetch/execute micro-sequencer paced by a one-hot four-beat timing generator.
// Define PHASE_CHECK_EN to build the sticky beat-sequence checker that freezes the FSM on error.
module micro_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] slow,
  input  logic       quick,
  input  logic       start,
  input  logic [2:0] ir_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       alu_add,
  output logic       acc_load,
  output logic       busy,
  output logic       halted,
  output logic [7:0] instr_cnt,
  output logic       phase_err
);

  // state | meaning
  // IDLE  | waiting for start at a W2 frame end
  // FETCH | W1 frame: read, latch opcode, bump PC
  // EXEC  | W2 frame: opcode-specific strobes, retires instruction
  // HALT  | parked after HLT until reset
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} state_t;

  localparam logic [3:0] T1 = 4'b1000;
  localparam logic [3:0] T2 = 4'b0100;
  localparam logic [3:0] T3 = 4'b0010;
  localparam logic [3:0] T4 = 4'b0001;

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_HLT   = 3'b111;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic       retire;
  logic       freeze;
  logic       frame_end;
  logic       w1_end;

  assign frame_end = (slow == T4) && !quick;
  assign w1_end    = (slow == T4) && quick;

`ifdef PHASE_CHECK_EN
  logic [3:0] slow_prev;
  logic       quick_prev;
  logic       prev_valid;
  logic       beat_bad;

  always_comb begin
    beat_bad = 1'b0;
    if ((slow == 4'b0000) || ((slow & (slow - 4'd1)) != 4'b0000)) begin
      beat_bad = 1'b1;
    end else if (prev_valid) begin
      if (slow != {slow_prev[0], slow_prev[3:1]}) beat_bad = 1'b1;
      // quick may only flip on the T4->T1 frame boundary
      if ((quick != quick_prev) && !((slow_prev == T4) && (slow == T1))) beat_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_err  <= 1'b0;
      prev_valid <= 1'b0;
      slow_prev  <= 4'b0000;
      quick_prev <= 1'b0;
    end else begin
      prev_valid <= 1'b1;
      slow_prev  <= slow;
      quick_prev <= quick;
      if (beat_bad) phase_err <= 1'b1;
    end
  end

  assign freeze = phase_err;
`else
  assign phase_err = 1'b0;
  assign freeze    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_q      <= 3'b000;
      instr_cnt <= 8'd0;
    end else if (!freeze) begin
      state <= state_nxt;
      if (ir_load) op_q <= ir_op;
      if (retire) instr_cnt <= instr_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      ST_IDLE:  if (frame_end && start) state_nxt = ST_FETCH;
      ST_FETCH: if (w1_end) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (frame_end) begin
          retire = 1'b1;
          if (op_q == OP_HLT)  state_nxt = ST_HALT;
          else if (start)      state_nxt = ST_FETCH;
          else                 state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_add  = 1'b0;
    acc_load = 1'b0;
    busy     = rst && ((state == ST_FETCH) || (state == ST_EXEC));
    halted   = rst && (state == ST_HALT);
    if (rst && !freeze) begin
      case (state)
        ST_FETCH: begin
          if (quick) begin
            mem_rd  = (slow == T1);
            ir_load = (slow == T2);
            pc_inc  = (slow == T3);
          end
        end
        ST_EXEC: begin
          if (!quick) begin
            case (op_q)
              OP_LOAD: begin
                mem_rd   = (slow == T1);
                acc_load = (slow == T2);
              end
              OP_STORE: mem_wr = (slow == T2);
              OP_ADD: begin
                mem_rd   = (slow == T1);
                alu_add  = (slow == T2);
                acc_load = (slow == T3);
              end
              OP_JMP:  pc_load = (slow == T2);
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq: directed and randomized frames for micro_seq, checked cycle by cycle
// against a frame-level reference model built from per-opcode beat tables.
`timescale 1ns/1ps
module tb_micro_seq;

  logic       clk, rst, quick, start;
  logic [3:0] slow;
  logic [2:0] ir_op;
  logic       mem_rd, mem_wr, ir_load, pc_inc, pc_load, alu_add, acc_load;
  logic       busy, halted, phase_err;
  logic [7:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  micro_seq dut (
    .clk(clk), .rst(rst), .slow(slow), .quick(quick), .start(start), .ir_op(ir_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .alu_add(alu_add), .acc_load(acc_load),
    .busy(busy), .halted(halted), .instr_cnt(instr_cnt), .phase_err(phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe vector order: {mem_rd, mem_wr, ir_load, pc_inc, pc_load, alu_add, acc_load}
  localparam logic [6:0] S_RD = 7'b1000000;
  localparam logic [6:0] S_WR = 7'b0100000;
  localparam logic [6:0] S_IL = 7'b0010000;
  localparam logic [6:0] S_PI = 7'b0001000;
  localparam logic [6:0] S_PL = 7'b0000100;
  localparam logic [6:0] S_AA = 7'b0000010;
  localparam logic [6:0] S_AL = 7'b0000001;

  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

  logic [6:0] fetch_pat [4];
  logic [6:0] exec_pat  [8][4];
  int         m_mode;
  logic [2:0] m_op;
  int         m_cnt;
  bit         m_perr;
  bit         m_known;
  int         beat;
  bit         w1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the timing generator plus model; entered just after a rising edge.
  task automatic step(input logic rst_v, input logic start_v, input logic [2:0] op_v, input bit glitch);
    logic [6:0] exp_str;
    rst   = rst_v;
    start = start_v;
    ir_op = op_v;
    quick = w1;
    if (glitch) slow = 4'b0110;
    else begin
      case (beat)
        0:       slow = 4'b1000;
        1:       slow = 4'b0100;
        2:       slow = 4'b0010;
        default: slow = 4'b0001;
      endcase
    end
    exp_str = 7'b0;
    if (rst_v && !m_perr && !glitch) begin
      if (m_mode == M_FETCH && w1)       exp_str = fetch_pat[beat];
      else if (m_mode == M_EXEC && !w1)  exp_str = exec_pat[m_op][beat];
    end
    @(negedge clk);
    chk("strobes", {25'd0, mem_rd, mem_wr, ir_load, pc_inc, pc_load, alu_add, acc_load}, {25'd0, exp_str});
    chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, rst_v && (m_mode == M_FETCH || m_mode == M_EXEC)});
    chk("halted", {31'd0, halted}, {31'd0, rst_v && (m_mode == M_HALT)});
    if (m_known) begin
      chk("instr_cnt", {24'd0, instr_cnt}, m_cnt);
      chk("phase_err", {31'd0, phase_err}, {31'd0, m_perr});
    end
    @(posedge clk);
    if (!rst_v) begin
      m_mode = M_IDLE; m_op = 3'd0; m_cnt = 0; m_perr = 1'b0; m_known = 1'b1;
    end else if (glitch) begin
`ifdef PHASE_CHECK_EN
      m_perr = 1'b1;
`endif
    end else if (!m_perr) begin
      if (m_mode == M_FETCH && w1 && beat == 1) m_op = op_v;
      if (beat == 3) begin
        if (m_mode == M_IDLE && !w1 && start_v)  m_mode = M_FETCH;
        else if (m_mode == M_FETCH && w1)        m_mode = M_EXEC;
        else if (m_mode == M_EXEC && !w1) begin
          m_cnt  = (m_cnt + 1) % 256;
          m_mode = (m_op == 3'd7) ? M_HALT : (start_v ? M_FETCH : M_IDLE);
        end
      end
    end
    if (!glitch) begin
      beat = (beat + 1) % 4;
      if (beat == 0) w1 = !w1;
    end
    #1;
  endtask

  task automatic frame(input logic [2:0] op, input logic st_end, input bit noisy);
    for (int b = 0; b < 4; b++)
      step(1'b1, (b == 3 || !noisy) ? st_end : 1'($urandom),
           (b == 1) ? op : 3'($urandom), 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 3'($urandom), 1'b0);
  endtask

  initial begin
    for (int o = 0; o < 8; o++)
      for (int b = 0; b < 4; b++) exec_pat[o][b] = 7'b0;
    fetch_pat[0] = S_RD; fetch_pat[1] = S_IL; fetch_pat[2] = S_PI; fetch_pat[3] = 7'b0;
    exec_pat[1][0] = S_RD; exec_pat[1][1] = S_AL;
    exec_pat[2][1] = S_WR;
    exec_pat[3][0] = S_RD; exec_pat[3][1] = S_AA; exec_pat[3][2] = S_AL;
    exec_pat[4][1] = S_PL;

    rst = 1'b0; start = 1'b0; ir_op = 3'd0; slow = 4'b0001; quick = 1'b0;
    beat = 0; w1 = 1'b1;
    m_mode = M_IDLE; m_op = 3'd0; m_cnt = 0; m_perr = 1'b0; m_known = 1'b0;
    @(posedge clk); #1;

    // reset through one W1 frame, then LOAD with start held
    do_reset(4);
    frame(3'd0, 1'b1, 1'b0);
    frame(3'd1, 1'b1, 1'b0);
    frame(3'd0, 1'b1, 1'b0);
    chk("load_cnt", {24'd0, instr_cnt}, 32'd1);

    // ADD, STORE, JMP back-to-back
    frame(3'd3, 1'b1, 1'b0); frame(3'd0, 1'b1, 1'b0);
    frame(3'd2, 1'b1, 1'b0); frame(3'd0, 1'b1, 1'b0);
    frame(3'd4, 1'b1, 1'b0); frame(3'd0, 1'b0, 1'b0);
    chk("prog_cnt", {24'd0, instr_cnt}, 32'd4);
    chk("prog_idle", {31'd0, busy}, 32'd0);

    // random programs with start and ir_op wiggling mid-frame
    for (int i = 0; i < 60; i++) frame(3'($urandom_range(6, 0)), 1'($urandom), 1'b1);

    // reset at EXEC T2 of LOAD
    do_reset(4);
    if (w1) frame(3'd0, 1'b0, 1'b0);
    frame(3'd0, 1'b1, 1'b0);
    frame(3'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'($urandom), 1'b0);
    step(1'b0, 1'b1, 3'($urandom), 1'b0);
    chk("abort_cnt", {24'd0, instr_cnt}, 32'd0);
    step(1'b1, 1'b0, 3'($urandom), 1'b0);
    step(1'b1, 1'b1, 3'($urandom), 1'b0);

    // HLT, then start ignored for several frames
    frame(3'd7, 1'b1, 1'b0);
    frame(3'd0, 1'b1, 1'b0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_cnt", {24'd0, instr_cnt}, 32'd1);
    for (int i = 0; i < 8; i++) frame(3'($urandom), 1'b1, 1'b1);
    chk("halt_still", {31'd0, halted}, 32'd1);
    do_reset(4);
    chk("halt_reset_cnt", {24'd0, instr_cnt}, 32'd0);

    // counter wrap over NOP encodings 000/101/110
    if (w1) frame(3'd0, 1'b0, 1'b0);
    frame(3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) begin
      frame((i % 3 == 0) ? 3'd0 : ((i % 3 == 1) ? 3'd5 : 3'd6), 1'b1, 1'b0);
      frame(3'd0, 1'b1, 1'b0);
    end
    chk("wrap_255", {24'd0, instr_cnt}, 32'd255);
    frame(3'd0, 1'b1, 1'b0);
    frame(3'd0, 1'b1, 1'b1);
    chk("wrap_0", {24'd0, instr_cnt}, 32'd0);

    // start dropped mid-EXEC: only the frame-end value matters
    frame(3'd0, 1'b1, 1'b0);
    frame(3'd0, 1'b0, 1'b1);
    chk("drop_idle", {31'd0, busy}, 32'd0);
    frame(3'd0, 1'b1, 1'b1);
    frame(3'd0, 1'b1, 1'b1);
    chk("resume_busy", {31'd0, busy}, 32'd1);

    // broken beat: slow=0110 for one cycle
    frame(3'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'd0, 1'b1);
    frame(3'd0, 1'b1, 1'b0);
    frame(3'd3, 1'b1, 1'b0);
`ifdef PHASE_CHECK_EN
    chk("perr_set", {31'd0, phase_err}, 32'd1);
`else
    chk("perr_tied", {31'd0, phase_err}, 32'd0);
`endif
    do_reset(4);
    chk("perr_clear", {31'd0, phase_err}, 32'd0);
    if (w1) frame(3'd0, 1'b0, 1'b0);
    frame(3'd0, 1'b1, 1'b0);
    frame(3'd2, 1'b1, 1'b0);
    frame(3'd0, 1'b0, 1'b0);
    chk("recover_cnt", {24'd0, instr_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
